// File: rtl/dvp_rgb565_capture.sv
// rtl/dvp_rgb565_capture.sv - DVP 8-bit camera capture to RGB565 pixels with FWFT pixel FIFO.
// Optional macro DVP_CAPTURE_COORD_EN adds per-pixel x/y coordinates carried through the FIFO.
module dvp_rgb565_capture #(
  parameter int RGB_PXL_W  = 16,
  parameter int DVP_DAT_W  = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 capture_en_i,
  input  logic                 dvp_pclk_i,
  input  logic                 dvp_vsync_i,
  input  logic                 dvp_href_i,
  input  logic [DVP_DAT_W-1:0] dvp_dat_i,
  output logic [RGB_PXL_W-1:0] rgb_pxl_o,
  output logic                 rgb_pxl_vld_o,
  input  logic                 rgb_pxl_rdy_i,
  output logic                 frame_start_o,
  output logic                 ovf_o,
`ifdef DVP_CAPTURE_COORD_EN
  output logic [11:0]          pxl_x_o,
  output logic [11:0]          pxl_y_o,
`endif
  input  logic                 ovf_clr_i
);

  localparam int AW = $clog2(FIFO_DEPTH);
`ifdef DVP_CAPTURE_COORD_EN
  localparam int FW = RGB_PXL_W + 24;
`else
  localparam int FW = RGB_PXL_W;
`endif
  localparam logic [AW:0] PTR_ONE = 1;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT_VS, ST_ACTIVE} state_t;

  logic                 r_pclk_s1, r_pclk_s2, r_pclk_s3;
  logic                 r_vs_s1, r_vs_s2, r_vs_s3;
  logic                 r_href_s1, r_href_s2;
  logic [DVP_DAT_W-1:0] r_dat_s1, r_dat_s2;

  state_t               r_state, w_state_nxt;
  logic                 w_frame_start;
  logic                 r_frame_start;
  logic                 r_phase;
  logic [DVP_DAT_W-1:0] r_hi;
  logic                 r_ovf;

  logic                 w_pclk_rise, w_vs_rise, w_vs_fall;
  logic                 w_byte_en, w_push;
  logic [FW-1:0]        w_wdata;

  logic [FW-1:0]        r_mem [FIFO_DEPTH];
  logic [AW:0]          r_wr_ptr, r_rd_ptr;
  logic                 w_empty, w_full, w_pop, w_wr, w_ovf_set;
  logic [FW-1:0]        w_head;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pclk_s1 <= 1'b0; r_pclk_s2 <= 1'b0; r_pclk_s3 <= 1'b0;
      r_vs_s1   <= 1'b0; r_vs_s2   <= 1'b0; r_vs_s3   <= 1'b0;
      r_href_s1 <= 1'b0; r_href_s2 <= 1'b0;
      r_dat_s1  <= '0;   r_dat_s2  <= '0;
    end else begin
      r_pclk_s1 <= dvp_pclk_i;  r_pclk_s2 <= r_pclk_s1; r_pclk_s3 <= r_pclk_s2;
      r_vs_s1   <= dvp_vsync_i; r_vs_s2   <= r_vs_s1;   r_vs_s3   <= r_vs_s2;
      r_href_s1 <= dvp_href_i;  r_href_s2 <= r_href_s1;
      r_dat_s1  <= dvp_dat_i;   r_dat_s2  <= r_dat_s1;
    end
  end

  assign w_pclk_rise = r_pclk_s2 & ~r_pclk_s3;
  assign w_vs_rise   = r_vs_s2 & ~r_vs_s3;
  assign w_vs_fall   = ~r_vs_s2 & r_vs_s3;

  always_comb begin
    w_state_nxt   = r_state;
    w_frame_start = 1'b0;
    case (r_state)
      ST_IDLE:    if (capture_en_i) w_state_nxt = ST_WAIT_VS;
      ST_WAIT_VS: begin
        if (!capture_en_i) begin
          w_state_nxt = ST_IDLE;
        end else if (w_vs_fall) begin
          w_state_nxt   = ST_ACTIVE;
          w_frame_start = 1'b1;
        end
      end
      ST_ACTIVE:  if (w_vs_rise) w_state_nxt = capture_en_i ? ST_WAIT_VS : ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_frame_start <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_frame_start <= w_frame_start;
    end
  end

  // vsync rising ends the frame, so a byte landing on that cycle is part of the discarded remainder
  assign w_byte_en = (r_state == ST_ACTIVE) & w_pclk_rise & r_href_s2 & ~w_vs_rise;
  assign w_push    = w_byte_en & r_phase;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase <= 1'b0;
      r_hi    <= '0;
    end else begin
      if ((r_state != ST_ACTIVE) || !r_href_s2 || w_vs_rise) begin
        r_phase <= 1'b0;
      end else if (w_byte_en) begin
        r_phase <= ~r_phase;
      end
      if (w_byte_en && !r_phase) r_hi <= r_dat_s2;
    end
  end

`ifdef DVP_CAPTURE_COORD_EN
  logic        r_href_s3;
  logic [11:0] r_x, r_y;
  logic        w_href_fall;

  assign w_href_fall = r_href_s3 & ~r_href_s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_href_s3 <= 1'b0;
      r_x       <= '0;
      r_y       <= '0;
    end else begin
      r_href_s3 <= r_href_s2;
      if ((r_state != ST_ACTIVE) || w_href_fall) begin
        r_x <= '0;
      end else if (w_push && (r_x != 12'hFFF)) begin
        r_x <= r_x + 12'd1;
      end
      if (w_frame_start) begin
        r_y <= '0;
      end else if ((r_state == ST_ACTIVE) && w_href_fall && (r_y != 12'hFFF)) begin
        r_y <= r_y + 12'd1;
      end
    end
  end

  assign w_wdata = {r_y, r_x, r_hi, r_dat_s2};
`else
  assign w_wdata = {r_hi, r_dat_s2};
`endif

  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop     = ~w_empty & rgb_pxl_rdy_i;
  assign w_wr      = w_push & (~w_full | w_pop);
  assign w_ovf_set = w_push & w_full & ~w_pop;

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr[AW-1:0]] <= w_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_ONE;
      r_ovf <= (r_ovf & ~ovf_clr_i) | w_ovf_set;
    end
  end

  // Head is masked when empty so the outputs read zero out of reset
  assign w_head        = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
  assign rgb_pxl_o     = w_head[RGB_PXL_W-1:0];
  assign rgb_pxl_vld_o = ~w_empty;
  assign frame_start_o = r_frame_start;
  assign ovf_o         = r_ovf;
`ifdef DVP_CAPTURE_COORD_EN
  assign pxl_x_o       = w_head[RGB_PXL_W +: 12];
  assign pxl_y_o       = w_head[RGB_PXL_W+12 +: 12];
`endif

endmodule

// File: tb/tb_dvp_rgb565_capture.sv
// tb/tb_dvp_rgb565_capture.sv - directed self-checking bench for dvp_rgb565_capture.
module tb_dvp_rgb565_capture;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        capture_en_i = 1'b0;
  logic        dvp_pclk_i = 1'b0;
  logic        dvp_vsync_i = 1'b0;
  logic        dvp_href_i = 1'b0;
  logic [7:0]  dvp_dat_i = 8'h00;
  logic [15:0] rgb_pxl_o;
  logic        rgb_pxl_vld_o;
  logic        rgb_pxl_rdy_i = 1'b0;
  logic        frame_start_o;
  logic        ovf_o;
  logic        ovf_clr_i = 1'b0;

  int total = 0;
  int bad = 0;
  int fs_cnt = 0;
  logic [15:0] pop_q [$];
  logic [7:0]  line_q [$];

  dvp_rgb565_capture #(.RGB_PXL_W(16), .DVP_DAT_W(8), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .capture_en_i(capture_en_i),
    .dvp_pclk_i(dvp_pclk_i), .dvp_vsync_i(dvp_vsync_i), .dvp_href_i(dvp_href_i),
    .dvp_dat_i(dvp_dat_i), .rgb_pxl_o(rgb_pxl_o), .rgb_pxl_vld_o(rgb_pxl_vld_o),
    .rgb_pxl_rdy_i(rgb_pxl_rdy_i), .frame_start_o(frame_start_o), .ovf_o(ovf_o),
    .ovf_clr_i(ovf_clr_i)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rgb_pxl_vld_o && rgb_pxl_rdy_i) pop_q.push_back(rgb_pxl_o);
    if (frame_start_o) fs_cnt <= fs_cnt + 1;
  end

  task automatic send_byte(input logic [7:0] b);
    dvp_dat_i  = b;
    dvp_pclk_i = 1'b0;
    repeat (2) @(negedge clk);
    dvp_pclk_i = 1'b1;
    repeat (2) @(negedge clk);
    dvp_pclk_i = 1'b0;
  endtask

  task automatic send_line();
    dvp_href_i = 1'b1;
    repeat (2) @(negedge clk);
    foreach (line_q[i]) send_byte(line_q[i]);
    repeat (2) @(negedge clk);
    dvp_href_i = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic frame_begin();
    dvp_vsync_i = 1'b1;
    repeat (5) @(negedge clk);
    dvp_vsync_i = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (rgb_pxl_vld_o !== 1'b0) begin bad++; $display("FAIL reset_vld got=%b exp=0", rgb_pxl_vld_o); end
    total++; if (rgb_pxl_o !== 16'h0000) begin bad++; $display("FAIL reset_pxl got=%h exp=0000", rgb_pxl_o); end
    total++; if (frame_start_o !== 1'b0) begin bad++; $display("FAIL reset_fs got=%b exp=0", frame_start_o); end
    total++; if (ovf_o !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", ovf_o); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int qb, fb;
    rgb_pxl_rdy_i = 1'b1;
    capture_en_i  = 1'b1;
    repeat (3) @(negedge clk);
    qb = pop_q.size(); fb = fs_cnt;
    frame_begin();
    total++; if (fs_cnt - fb != 1) begin bad++; $display("FAIL basic_frame_start got=%0d exp=1", fs_cnt - fb); end
    line_q = '{8'hF8, 8'h1F, 8'h07, 8'hE0};
    send_line();
    total++; if (pop_q.size() - qb != 2) begin bad++; $display("FAIL basic_count got=%0d exp=2", pop_q.size() - qb); end
    total++; if (pop_q[qb] !== 16'hF81F) begin bad++; $display("FAIL basic_px0 got=%h exp=F81F", pop_q[qb]); end
    total++; if (pop_q[qb+1] !== 16'h07E0) begin bad++; $display("FAIL basic_px1 got=%h exp=07E0", pop_q[qb+1]); end
    total++; if (ovf_o !== 1'b0) begin bad++; $display("FAIL basic_ovf got=%b exp=0", ovf_o); end
    total++; if (fs_cnt - fb != 1) begin bad++; $display("FAIL basic_fs_once got=%0d exp=1", fs_cnt - fb); end
  endtask

  task automatic test_odd_byte();
    int qb;
    frame_begin();
    qb = pop_q.size();
    line_q = '{8'h12, 8'h34, 8'h56};
    send_line();
    line_q = '{8'hAB, 8'hCD};
    send_line();
    total++; if (pop_q.size() - qb != 2) begin bad++; $display("FAIL odd_count got=%0d exp=2", pop_q.size() - qb); end
    total++; if (pop_q[qb] !== 16'h1234) begin bad++; $display("FAIL odd_px0 got=%h exp=1234", pop_q[qb]); end
    total++; if (pop_q[qb+1] !== 16'hABCD) begin bad++; $display("FAIL odd_px1 got=%h exp=ABCD", pop_q[qb+1]); end
  endtask

  task automatic test_overflow();
    int qb;
    rgb_pxl_rdy_i = 1'b0;
    frame_begin();
    line_q = '{8'hA0, 8'h00, 8'hA0, 8'h01, 8'hA0, 8'h02, 8'hA0, 8'h03, 8'hA0, 8'h04, 8'hA0, 8'h05};
    send_line();
    total++; if (ovf_o !== 1'b1) begin bad++; $display("FAIL ovf_set got=%b exp=1", ovf_o); end
    total++; if (rgb_pxl_vld_o !== 1'b1 || rgb_pxl_o !== 16'hA000) begin bad++; $display("FAIL ovf_head got=%b/%h exp=1/A000", rgb_pxl_vld_o, rgb_pxl_o); end
    ovf_clr_i = 1'b1;
    @(negedge clk);
    ovf_clr_i = 1'b0;
    @(negedge clk);
    total++; if (ovf_o !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%b exp=0", ovf_o); end
    qb = pop_q.size();
    rgb_pxl_rdy_i = 1'b1;
    repeat (8) @(negedge clk);
    total++; if (pop_q.size() - qb != 4) begin bad++; $display("FAIL ovf_drain_count got=%0d exp=4", pop_q.size() - qb); end
    for (int k = 0; k < 4; k++) begin
      total++; if (pop_q[qb+k] !== (16'hA000 + 16'(k))) begin bad++; $display("FAIL ovf_drain_px%0d got=%h exp=%h", k, pop_q[qb+k], 16'hA000 + 16'(k)); end
    end
    total++; if (rgb_pxl_vld_o !== 1'b0) begin bad++; $display("FAIL ovf_empty got=%b exp=0", rgb_pxl_vld_o); end
  endtask

  task automatic test_full_pop();
    int qb;
    rgb_pxl_rdy_i = 1'b0;
    frame_begin();
    qb = pop_q.size();
    dvp_href_i = 1'b1;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      send_byte(8'hB0);
      send_byte(8'(k));
    end
    send_byte(8'hB0);
    dvp_dat_i  = 8'h04;
    dvp_pclk_i = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (rgb_pxl_vld_o !== 1'b1 || rgb_pxl_o !== 16'hB000) begin bad++; $display("FAIL fullpop_pre got=%b/%h exp=1/B000", rgb_pxl_vld_o, rgb_pxl_o); end
    dvp_pclk_i = 1'b1;
    repeat (2) @(negedge clk);
    rgb_pxl_rdy_i = 1'b1;
    @(negedge clk);
    rgb_pxl_rdy_i = 1'b0;
    total++; if (ovf_o !== 1'b0) begin bad++; $display("FAIL fullpop_ovf got=%b exp=0", ovf_o); end
    total++; if (rgb_pxl_o !== 16'hB001) begin bad++; $display("FAIL fullpop_head got=%h exp=B001", rgb_pxl_o); end
    dvp_pclk_i = 1'b0;
    repeat (2) @(negedge clk);
    dvp_href_i = 1'b0;
    repeat (4) @(negedge clk);
    rgb_pxl_rdy_i = 1'b1;
    repeat (8) @(negedge clk);
    total++; if (pop_q.size() - qb != 5) begin bad++; $display("FAIL fullpop_count got=%0d exp=5", pop_q.size() - qb); end
    for (int k = 0; k < 5; k++) begin
      total++; if (pop_q[qb+k] !== (16'hB000 + 16'(k))) begin bad++; $display("FAIL fullpop_px%0d got=%h exp=%h", k, pop_q[qb+k], 16'hB000 + 16'(k)); end
    end
  endtask

  task automatic test_disabled();
    int qb, fb;
    qb = pop_q.size(); fb = fs_cnt;
    capture_en_i = 1'b0;
    frame_begin();
    line_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    send_line();
    capture_en_i = 1'b1;
    repeat (3) @(negedge clk);
    send_line();
    total++; if (pop_q.size() - qb != 0) begin bad++; $display("FAIL dis_pixels got=%0d exp=0", pop_q.size() - qb); end
    total++; if (fs_cnt - fb != 0) begin bad++; $display("FAIL dis_frame_start got=%0d exp=0", fs_cnt - fb); end
    total++; if (rgb_pxl_vld_o !== 1'b0) begin bad++; $display("FAIL dis_vld got=%b exp=0", rgb_pxl_vld_o); end
  endtask

  task automatic test_reset_mid();
    int fb;
    rgb_pxl_rdy_i = 1'b0;
    frame_begin();
    line_q = '{8'hC1, 8'h11, 8'hC2, 8'h22};
    send_line();
    total++; if (rgb_pxl_vld_o !== 1'b1 || rgb_pxl_o !== 16'hC111) begin bad++; $display("FAIL rst_pre got=%b/%h exp=1/C111", rgb_pxl_vld_o, rgb_pxl_o); end
    dvp_href_i = 1'b1;
    repeat (2) @(negedge clk);
    send_byte(8'hC3);
    rst_n = 1'b0;
    #1;
    total++; if (rgb_pxl_vld_o !== 1'b0 || rgb_pxl_o !== 16'h0000) begin bad++; $display("FAIL rst_mid_pxl got=%b/%h exp=0/0000", rgb_pxl_vld_o, rgb_pxl_o); end
    total++; if (ovf_o !== 1'b0 || frame_start_o !== 1'b0) begin bad++; $display("FAIL rst_mid_flags got=%b/%b exp=0/0", ovf_o, frame_start_o); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    dvp_href_i = 1'b0;
    repeat (4) @(negedge clk);
    fb = fs_cnt;
    line_q = '{8'hD1, 8'hD2, 8'hD3, 8'hD4};
    send_line();
    total++; if (rgb_pxl_vld_o !== 1'b0) begin bad++; $display("FAIL rst_wait_vs got=%b exp=0", rgb_pxl_vld_o); end
    frame_begin();
    total++; if (fs_cnt - fb != 1) begin bad++; $display("FAIL rst_new_frame got=%0d exp=1", fs_cnt - fb); end
    line_q = '{8'hE1, 8'hE2};
    send_line();
    total++; if (rgb_pxl_vld_o !== 1'b1 || rgb_pxl_o !== 16'hE1E2) begin bad++; $display("FAIL rst_new_px got=%b/%h exp=1/E1E2", rgb_pxl_vld_o, rgb_pxl_o); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_odd_byte();
    test_overflow();
    test_full_pop();
    test_disabled();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
